// File: rtl/transmitter.sv
// Hamming(14,10) command transmitter: encodes {dir_cmd, speed_cmd, mode} and
// serialises the codeword LSB-first onto the idle-high SASS line with start/stop/gap slots.
module transmitter #(
  parameter int  clk_f  = 50_000_000,
  parameter int  range  = 1_000_000,
  parameter real t      = 0.1,
  parameter int  data_l = 14,
  parameter int  cmd_l  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [1:0]       mode,
  input  logic [cmd_l-1:0] speed_cmd,
  input  logic [cmd_l-1:0] dir_cmd,
  input  logic [3:0]       err_in,
  output logic             s,
  output logic             ready,
  output logic [7:0]       frame_cnt
);

  localparam int T_D = int'(real'(clk_f) * t / real'(range));
  localparam int TW  = (T_D > 2) ? $clog2(T_D) : 1;
  localparam int DW  = 2 * cmd_l + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [3:0]        bit_q, bit_d;
  logic [data_l-1:0] cw_q, cw_d;
  logic              s_d;
  logic [7:0]        cnt_d;
  logic [DW-1:0]     d;
  logic [3:0]        p;
  logic [data_l-1:0] cw_enc;
  logic              slot_end;

  always_comb begin
    d    = {dir_cmd, speed_cmd, mode};
    p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8];
    p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9];
    p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9];
    p[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9];
    cw_enc = {d[9:4], p[3], d[3:1], p[2], d[0], p[1], p[0]};
    // err_in values 0 and 15 leave the codeword untouched.
    if (err_in >= 4'd1 && err_in <= 4'd14)
      cw_enc = cw_enc ^ (data_l'(1) << (err_in - 4'd1));
  end

  assign slot_end = (timer_q == TW'(T_D - 1));
  assign ready    = (state_q == IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    cw_d    = cw_q;
    s_d     = s;
    cnt_d   = frame_cnt;

    if (state_q == IDLE) begin
      timer_d = '0;
      if (send) begin
        state_d = START;
        cw_d    = cw_enc;
        s_d     = 1'b0;
      end
    end else if (!slot_end) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = '0;
          s_d     = cw_q[0];
        end
        DATA: begin
          if (bit_q == 4'(data_l - 1)) begin
            state_d = STOP;
            s_d     = 1'b0;
          end else begin
            bit_d = bit_q + 4'd1;
            s_d   = cw_q[bit_q + 4'd1];
          end
        end
        STOP: begin
          state_d = GAP;
          s_d     = 1'b1;
          cnt_d   = frame_cnt + 8'd1;
        end
        GAP: begin
          // A held send starts the next frame straight out of the gap.
          if (send) begin
            state_d = START;
            cw_d    = cw_enc;
            s_d     = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      cw_q      <= '0;
      s         <= 1'b1;
      frame_cnt <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      cw_q      <= cw_d;
      s         <= s_d;
      frame_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: frames are sampled at slot mid-points (T_D=5)
// and compared against hand-computed codewords and a Hamming syndrome decoder.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [1:0] mode;
  logic [3:0] speed_cmd, dir_cmd, err_in;
  logic       s, ready;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  logic [13:0] got_cw;
  logic        got_start, got_stop, got_gap, got_ready_after;
  int          ready_low;

  transmitter dut (
    .clk(clk), .rst(rst), .send(send), .mode(mode), .speed_cmd(speed_cmd),
    .dir_cmd(dir_cmd), .err_in(err_in), .s(s), .ready(ready), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Syndrome-decode a received codeword back to its 10 data bits.
  function automatic logic [9:0] decode(input logic [13:0] c);
    logic [3:0]  syn;
    logic [13:0] x;
    syn = '0;
    x   = c;
    for (int i = 0; i < 14; i++)
      if (x[i]) syn = syn ^ 4'(i + 1);
    if (syn != 4'd0 && syn <= 4'd14) x[syn - 4'd1] = ~x[syn - 4'd1];
    return {x[13:8], x[6:4], x[2]};
  endfunction

  // One frame: request on a negedge, E0 is the next posedge, samples at negedges n=0..85.
  task automatic run_frame(input logic [1:0] m, input logic [3:0] sp, input logic [3:0] dr,
                           input logic [3:0] er);
    @(negedge clk);
    mode = m; speed_cmd = sp; dir_cmd = dr; err_in = er; send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    ready_low = 0;
    got_cw = '0;
    for (int n = 0; n < 85; n++) begin
      if (n > 0) @(negedge clk);
      if (!ready) ready_low++;
      if (n == 2) got_start = s;
      if (n >= 7 && n <= 72 && (n % 5) == 2) got_cw[(n - 7) / 5] = s;
      if (n == 77) got_stop = s;
      if (n == 82) got_gap = s;
    end
    @(negedge clk);
    got_ready_after = ready;
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; mode = '0; speed_cmd = '0; dir_cmd = '0; err_in = '0;
    repeat (2) @(negedge clk);
    check("reset_s", s, 1);
    check("reset_ready", ready, 1);
    check("reset_cnt", frame_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero frame
    run_frame(2'd0, 4'd0, 4'd0, 4'd0);
    exp_cnt++;
    check("zero_start", got_start, 0);
    check("zero_cw", got_cw, 14'h0000);
    check("zero_stop", got_stop, 0);
    check("zero_gap", got_gap, 1);
    check("zero_ready_low", ready_low, 85);
    check("zero_ready_after", got_ready_after, 1);
    check("zero_cnt", frame_cnt, exp_cnt);

    // Encoding vector
    run_frame(2'd1, 4'd5, 4'd10, 4'd0);
    exp_cnt++;
    check("enc_start", got_start, 0);
    check("enc_cw", got_cw, 14'h29AE);
    check("enc_stop", got_stop, 0);
    check("enc_gap", got_gap, 1);
    check("enc_cnt", frame_cnt, exp_cnt);

    run_frame(2'd1, 4'd5, 4'd10, 4'd3);
    exp_cnt++;
    check("err3_cw", got_cw, 14'h29AA);
    run_frame(2'd1, 4'd5, 4'd10, 4'd15);
    exp_cnt++;
    check("err15_cw", got_cw, 14'h29AE);
    run_frame(2'd3, 4'd15, 4'd15, 4'd0);
    exp_cnt++;
    check("ones_cw", got_cw, 14'h3F74);
    check("ones_cnt", frame_cnt, exp_cnt);

    // Every single-bit injection position, checked raw and after correction
    for (int e = 1; e <= 14; e++) begin
      run_frame(2'd1, 4'd5, 4'd10, 4'(e));
      exp_cnt++;
      check("errsweep_cw", got_cw, 14'h29AE ^ (14'h0001 << (e - 1)));
      check("errsweep_fix", decode(got_cw), 10'h295);
    end
    check("errsweep_cnt", frame_cnt, exp_cnt);

    // Mid-frame send pulse and input changes are ignored
    @(negedge clk);
    mode = 2'd1; speed_cmd = 4'd5; dir_cmd = 4'd10; err_in = 4'd0; send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    got_cw = '0;
    for (int n = 0; n < 91; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 10) begin
        send = 1'b1; mode = 2'd2; speed_cmd = 4'd3; dir_cmd = 4'd7; err_in = 4'd5;
      end
      if (n == 11) send = 1'b0;
      if (n >= 7 && n <= 72 && (n % 5) == 2) got_cw[(n - 7) / 5] = s;
    end
    exp_cnt++;
    check("hs_cw", got_cw, 14'h29AE);
    check("hs_ready", ready, 1);
    check("hs_idle_s", s, 1);
    check("hs_cnt", frame_cnt, exp_cnt);

    // Send held high: three back-to-back frames
    @(negedge clk);
    mode = 2'd0; speed_cmd = 4'd0; dir_cmd = 4'd0; err_in = 4'd0; send = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 255; n++) begin
      @(negedge clk);
      if (n == 0)   check("b2b_start0", s, 0);
      if (n == 84)  check("b2b_gap0", s, 1);
      if (n == 85)  check("b2b_start1", s, 0);
      if (n == 169) check("b2b_gap1", s, 1);
      if (n == 170) begin
        check("b2b_start2", s, 0);
        send = 1'b0;
      end
      if (n == 254) check("b2b_busy", ready, 0);
    end
    exp_cnt += 3;
    check("b2b_ready", ready, 1);
    check("b2b_cnt", frame_cnt, exp_cnt);

    // Loopback-style sweep: every mode with speed=dir=k decodes back
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 16; k++) begin
        run_frame(2'(m), 4'(k), 4'(k), 4'd0);
        exp_cnt++;
        check("sweep_data", decode(got_cw), {4'(k), 4'(k), 2'(m)});
      end
    check("sweep_cnt", frame_cnt, exp_cnt[7:0]);

    // Asynchronous reset during DATA
    @(negedge clk);
    mode = 2'd0; speed_cmd = 4'd0; dir_cmd = 4'd0; err_in = 4'd0; send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_s", s, 0);
    check("pre_rst_ready", ready, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_s", s, 1);
    check("async_rst_ready", ready, 1);
    check("async_rst_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    run_frame(2'd3, 4'd15, 4'd15, 4'd0);
    exp_cnt++;
    check("post_rst_start", got_start, 0);
    check("post_rst_cw", got_cw, 14'h3F74);
    check("post_rst_stop", got_stop, 0);
    check("post_rst_cnt", frame_cnt, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
